// File: rtl/ara_pkg.sv
// Shared request/response types for the sequencer <-> processing-element protocol.
// Also holds the hazard helpers used by every PE-side instruction queue.
package ara_pkg;

   localparam int unsigned NrVInsn = 8;

   typedef logic [$clog2(NrVInsn)-1:0] vid_t;

   typedef enum logic [2:0] {
      VFU_None,
      VFU_Alu,
      VFU_MFpu,
      VFU_SlideUnit,
      VFU_MaskUnit,
      VFU_LoadUnit,
      VFU_StoreUnit
   } vfu_e;

   // Cardinality of vfu_e; sizes per-PE acceptance masks.
   localparam int unsigned NrVFUs = 7;

   typedef struct packed {
      vid_t               id;
      vfu_e               vfu;
      logic [5:0]         op;
      logic               vm;
      logic [4:0]         vd;
      logic [4:0]         vs1;
      logic [4:0]         vs2;
      logic [15:0]        vl;
      logic [NrVInsn-1:0] hazard_vs1;
      logic [NrVInsn-1:0] hazard_vs2;
      logic [NrVInsn-1:0] hazard_vm;
      logic [NrVInsn-1:0] hazard_vd;
      logic [NrVInsn-1:0] vinsn_running;
   } pe_req_t;

   typedef struct packed {
      logic [NrVInsn-1:0] vinsn_done;
   } pe_resp_t;

   function automatic pe_req_t mask_hazards(input pe_req_t req, input logic [NrVInsn-1:0] running);
      pe_req_t m;
      m            = req;
      m.hazard_vs1 = req.hazard_vs1 & running;
      m.hazard_vs2 = req.hazard_vs2 & running;
      m.hazard_vm  = req.hazard_vm  & running;
      m.hazard_vd  = req.hazard_vd  & running;
      return m;
   endfunction

   function automatic logic hazard_free(input pe_req_t req);
      return ~|{req.hazard_vs1, req.hazard_vs2, req.hazard_vm, req.hazard_vd};
   endfunction

endpackage

// File: rtl/ara_pe_vinsn_queue.sv
// PE-side instruction queue: accepts broadcast requests for this PE, issues the head once
// its hazards clear, and returns a one-cycle vinsn_done pulse when the datapath completes it.
module ara_pe_vinsn_queue
   import ara_pkg::*;
#(
   parameter int unsigned       QueueDepth    = 4,
   parameter logic [NrVFUs-1:0] AcceptVfuMask = '0,
   parameter logic              AcceptMasked  = 1'b0
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  pe_req_t  pe_req_i,
   input  logic     pe_req_valid_i,
   output logic     pe_req_ready_o,
   output pe_resp_t pe_resp_o,
   output pe_req_t  issue_req_o,
   output logic     issue_valid_o,
   input  logic     issue_ready_i,
   input  logic     exec_done_i
);

   localparam int unsigned PtrW = $clog2(QueueDepth);
   typedef logic [PtrW-1:0] ptr_t;
   typedef logic [PtrW:0]   cnt_t;

   pe_req_t            r_buf [QueueDepth];
   ptr_t               r_wr_ptr;
   ptr_t               r_iss_ptr;
   ptr_t               r_cmt_ptr;
   cnt_t               r_cnt;
   cnt_t               r_iss_cnt;
   logic [NrVInsn-1:0] r_accepted;
   pe_resp_t           r_resp;

   pe_req_t            w_buf_next [QueueDepth];
   ptr_t               w_wr_ptr_next;
   ptr_t               w_iss_ptr_next;
   ptr_t               w_cmt_ptr_next;
   cnt_t               w_cnt_next;
   cnt_t               w_iss_cnt_next;
   logic [NrVInsn-1:0] w_accepted_next;
   pe_resp_t           w_resp_next;

   pe_req_t            w_head;
   vid_t               w_cmt_id;
   logic               w_pending;
   logic               w_full;
   logic               w_match;
   logic               w_accept;
   logic               w_issue_valid;
   logic               w_issue;
   logic               w_commit;

   always_comb begin
      w_head        = mask_hazards(r_buf[r_iss_ptr], pe_req_i.vinsn_running);
      w_pending     = (r_cnt > r_iss_cnt);
      w_full        = (r_cnt == cnt_t'(QueueDepth));
      w_match       = AcceptVfuMask[pe_req_i.vfu] || (AcceptMasked && !pe_req_i.vm);
      // accepted_q keeps a request held across several cycles from being stored twice
      w_accept      = pe_req_valid_i && w_match && !w_full && !r_accepted[pe_req_i.id];
      w_issue_valid = w_pending && hazard_free(w_head);
      w_issue       = w_issue_valid && issue_ready_i;
      w_commit      = exec_done_i && (r_iss_cnt != '0);
      w_cmt_id      = r_buf[r_cmt_ptr].id;

      for (int i = 0; i < QueueDepth; i++) begin
         w_buf_next[i] = mask_hazards(r_buf[i], pe_req_i.vinsn_running);
      end
      if (w_accept) begin
         w_buf_next[r_wr_ptr] = mask_hazards(pe_req_i, pe_req_i.vinsn_running);
      end

      w_wr_ptr_next  = w_accept ? r_wr_ptr + ptr_t'(1) : r_wr_ptr;
      w_iss_ptr_next = w_issue  ? r_iss_ptr + ptr_t'(1) : r_iss_ptr;
      w_cmt_ptr_next = w_commit ? r_cmt_ptr + ptr_t'(1) : r_cmt_ptr;

      w_cnt_next = r_cnt;
      unique case ({w_accept, w_commit})
         2'b10:   w_cnt_next = r_cnt + cnt_t'(1);
         2'b01:   w_cnt_next = r_cnt - cnt_t'(1);
         default: w_cnt_next = r_cnt;
      endcase

      w_iss_cnt_next = r_iss_cnt;
      unique case ({w_issue, w_commit})
         2'b10:   w_iss_cnt_next = r_iss_cnt + cnt_t'(1);
         2'b01:   w_iss_cnt_next = r_iss_cnt - cnt_t'(1);
         default: w_iss_cnt_next = r_iss_cnt;
      endcase

      w_accepted_next = r_accepted;
      w_resp_next     = '0;
      if (w_commit) begin
         w_accepted_next[w_cmt_id] = 1'b0;
         w_resp_next.vinsn_done[w_cmt_id] = 1'b1;
      end
      if (w_accept) begin
         w_accepted_next[pe_req_i.id] = 1'b1;
      end

      pe_req_ready_o = !w_full;
      pe_resp_o      = r_resp;
      issue_valid_o  = w_issue_valid;
      issue_req_o    = w_pending ? w_head : '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < QueueDepth; i++) begin
            r_buf[i] <= '0;
         end
         r_wr_ptr   <= '0;
         r_iss_ptr  <= '0;
         r_cmt_ptr  <= '0;
         r_cnt      <= '0;
         r_iss_cnt  <= '0;
         r_accepted <= '0;
         r_resp     <= '0;
      end else begin
         r_buf      <= w_buf_next;
         r_wr_ptr   <= w_wr_ptr_next;
         r_iss_ptr  <= w_iss_ptr_next;
         r_cmt_ptr  <= w_cmt_ptr_next;
         r_cnt      <= w_cnt_next;
         r_iss_cnt  <= w_iss_cnt_next;
         r_accepted <= w_accepted_next;
         r_resp     <= w_resp_next;
      end
   end

endmodule

// File: tb/tb_ara_pe_vinsn_queue.sv
// Scoreboard bench for ara_pe_vinsn_queue: stimulus pushes expected issue/done ids,
// a negedge monitor pops and compares whenever the DUT issues or pulses vinsn_done.
module tb_ara_pe_vinsn_queue;
   import ara_pkg::*;

   // Alu only (bit VFU_Alu = 1)
   localparam logic [NrVFUs-1:0] AluOnly = 7'b000_0010;

   logic     clk = 1'b0;
   logic     rst_n;
   pe_req_t  req_body;
   pe_req_t  pe_req;
   logic [NrVInsn-1:0] running;
   logic     req_valid;
   logic     issue_ready;
   logic     exec_done;

   logic     ready1, ready2, iv1, iv2;
   pe_resp_t resp1, resp2;
   pe_req_t  ireq1, ireq2;

   int n_checks = 0;
   int n_fail   = 0;
   int tb_iss_cnt = 0;
   vid_t exp_issue[$];
   vid_t exp_done[$];
   vid_t model[$];

   always #5 clk = ~clk;

   always_comb begin
      pe_req = req_body;
      pe_req.vinsn_running = running;
   end

   ara_pe_vinsn_queue #(.QueueDepth(4), .AcceptVfuMask(AluOnly), .AcceptMasked(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .pe_req_i(pe_req), .pe_req_valid_i(req_valid),
      .pe_req_ready_o(ready1), .pe_resp_o(resp1), .issue_req_o(ireq1),
      .issue_valid_o(iv1), .issue_ready_i(issue_ready), .exec_done_i(exec_done)
   );

   ara_pe_vinsn_queue #(.QueueDepth(4), .AcceptVfuMask(AluOnly), .AcceptMasked(1'b0)) dut_nomask (
      .clk_i(clk), .rst_ni(rst_n), .pe_req_i(pe_req), .pe_req_valid_i(req_valid),
      .pe_req_ready_o(ready2), .pe_resp_o(resp2), .issue_req_o(ireq2),
      .issue_valid_o(iv2), .issue_ready_i(issue_ready), .exec_done_i(exec_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every issue handshake and every done pulse against the scoreboard.
   always @(negedge clk) begin
      vid_t e;
      if (exec_done) begin
         check("exec_done_has_issued", 32'(tb_iss_cnt > 0), 32'd1);
         if (tb_iss_cnt > 0) tb_iss_cnt--;
      end
      if (iv1 && issue_ready) begin
         if (exp_issue.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL issue_unexpected: got id %0d expected none", ireq1.id);
         end else begin
            e = exp_issue.pop_front();
            $display("ISSUE id=%0d (expected %0d)", ireq1.id, e);
            check("issue_id", 32'(ireq1.id), 32'(e));
            check("issue_hazards_clear", 32'(ireq1.hazard_vs1 | ireq1.hazard_vs2 | ireq1.hazard_vm | ireq1.hazard_vd), 32'd0);
         end
         tb_iss_cnt++;
      end
      if (resp1.vinsn_done != '0) begin
         if (exp_done.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL done_unexpected: got %b expected none", resp1.vinsn_done);
         end else begin
            e = exp_done.pop_front();
            $display("DONE vinsn_done=%b (expected id %0d)", resp1.vinsn_done, e);
            check("done_onehot", 32'(resp1.vinsn_done), 32'd1 << e);
         end
      end
   end

   function automatic pe_req_t mk_req(input int id, input vfu_e vfu, input logic vm, input logic [NrVInsn-1:0] hz);
      pe_req_t r;
      r            = '0;
      r.id         = vid_t'(id);
      r.vfu        = vfu;
      r.vm         = vm;
      r.op         = 6'(id + 2);
      r.vd         = 5'(id + 1);
      r.vs1        = 5'(id + 8);
      r.vl         = 16'(id * 3 + 1);
      r.hazard_vs1 = hz;
      return r;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
      req_valid   = 1'b0;
      issue_ready = 1'b0;
      exec_done   = 1'b0;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic expect_accept(input int id);
      exp_issue.push_back(vid_t'(id));
      model.push_back(vid_t'(id));
   endtask

   task automatic do_commit();
      exec_done = 1'b1;
      exp_done.push_back(model.pop_front());
   endtask

   task automatic send(input int id, input vfu_e vfu, input logic vm, input logic [NrVInsn-1:0] hz, input bit exp);
      cyc();
      req_body  = mk_req(id, vfu, vm, hz);
      req_valid = 1'b1;
      if (exp) expect_accept(id);
      settle();
   endtask

   // Drains k entries that are all stored, unissued and hazard-free.
   task automatic drain(input int k);
      cyc(); issue_ready = 1'b1; settle();
      for (int i = 1; i < k; i++) begin
         cyc(); issue_ready = 1'b1; do_commit(); settle();
      end
      cyc(); do_commit(); settle();
   endtask

   task automatic commit1();
      cyc(); do_commit(); settle();
   endtask

   task automatic pulse_reset();
      cyc(); rst_n = 1'b0;
      repeat (2) cyc();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; issue_ready = 1'b0; exec_done = 1'b0;
      running = '0; req_body = '0;
      repeat (3) @(posedge clk);
      settle();
      check("rst_ready", 32'(ready1), 32'd1);
      check("rst_issue_valid", 32'(iv1), 32'd0);
      check("rst_issue_req", 32'(ireq1 != '0), 32'd0);
      check("rst_resp", 32'(resp1.vinsn_done), 32'd0);
      @(posedge clk); #1; rst_n = 1'b1;

      // 1: single request held 4 cycles, stored once, issued, completed
      send(3, VFU_Alu, 1'b1, '0, 1'b1);
      check("t1_ready", 32'(ready1), 32'd1);
      check("t1_no_issue_same_cycle", 32'(iv1), 32'd0);
      cyc(); req_valid = 1'b1; issue_ready = 1'b1; settle();
      check("t1_issue_next_cycle", 32'(iv1), 32'd1);
      for (int i = 0; i < 2; i++) begin
         cyc(); req_valid = 1'b1; issue_ready = 1'b1; settle();
         check("t1_dedup_no_second_entry", 32'(iv1), 32'd0);
      end
      commit1();
      check("t1_done_not_same_cycle", 32'(resp1.vinsn_done), 32'd0);
      cyc(); settle();
      check("t1_done_pulse", 32'(resp1.vinsn_done), 32'h08);
      cyc(); settle();
      check("t1_done_one_cycle", 32'(resp1.vinsn_done), 32'd0);

      // 2: full queue blocks id 4 until one commit frees a slot
      for (int i = 0; i < 4; i++) send(i, VFU_Alu, 1'b1, '0, 1'b1);
      cyc(); req_valid = 1'b1; req_body = mk_req(4, VFU_Alu, 1'b1, '0); settle();
      check("t2_full_not_ready", 32'(ready1), 32'd0);
      check("t2_head_held", 32'(ireq1.id), 32'd0);
      cyc(); req_valid = 1'b1; issue_ready = 1'b1; settle();
      cyc(); req_valid = 1'b1; do_commit(); settle();
      check("t2_no_commit_bypass", 32'(ready1), 32'd0);
      cyc(); req_valid = 1'b1; expect_accept(4); settle();
      check("t2_ready_after_commit", 32'(ready1), 32'd1);
      cyc(); req_valid = 1'b1; settle();
      check("t2_id4_stored_full_again", 32'(ready1), 32'd0);
      drain(4);

      // 3: head waits on hazard_vs1 bit 2 while that instruction is running
      running = 8'h04;
      send(5, VFU_Alu, 1'b1, 8'h04, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cyc(); issue_ready = 1'b1; settle();
         check("t3_hazard_blocks", 32'(iv1), 32'd0);
      end
      cyc(); issue_ready = 1'b1; running = '0; settle();
      check("t3_issue_when_bit_drops", 32'(iv1), 32'd1);
      check("t3_hazard_masked_out", 32'(ireq1.hazard_vs1), 32'd0);
      commit1();

      // 5: accept and commit together at cnt=2, write ptr wraps 3 -> 0
      send(6, VFU_Alu, 1'b1, '0, 1'b1);
      send(7, VFU_Alu, 1'b1, '0, 1'b1);
      drain(2);
      send(0, VFU_Alu, 1'b1, '0, 1'b1);
      send(1, VFU_Alu, 1'b1, '0, 1'b1);
      cyc(); issue_ready = 1'b1; settle();
      cyc(); req_valid = 1'b1; req_body = mk_req(2, VFU_Alu, 1'b1, '0);
      do_commit(); expect_accept(2); settle();
      check("t5_ready_during_accept_commit", 32'(ready1), 32'd1);
      send(3, VFU_Alu, 1'b1, '0, 1'b1);
      send(4, VFU_Alu, 1'b1, '0, 1'b1);
      cyc(); req_valid = 1'b1; req_body = mk_req(5, VFU_Alu, 1'b1, '0); settle();
      check("t5_cnt_stayed_two", 32'(ready1), 32'd0);
      drain(4);

      // 6: reset with 3 entries (2 issued) drops everything, no done pulse
      send(0, VFU_Alu, 1'b1, '0, 1'b1);
      send(1, VFU_Alu, 1'b1, '0, 1'b1);
      send(2, VFU_Alu, 1'b1, '0, 1'b1);
      cyc(); issue_ready = 1'b1; settle();
      cyc(); issue_ready = 1'b1; settle();
      cyc(); rst_n = 1'b0; #1;
      check("t6_rst_ready", 32'(ready1), 32'd1);
      check("t6_rst_issue_valid", 32'(iv1), 32'd0);
      check("t6_rst_issue_req", 32'(ireq1 != '0), 32'd0);
      check("t6_rst_resp", 32'(resp1.vinsn_done), 32'd0);
      exp_issue.delete(); model.delete(); tb_iss_cnt = 0;
      repeat (2) cyc();
      rst_n = 1'b1;
      send(1, VFU_Alu, 1'b1, '0, 1'b1);
      cyc(); issue_ready = 1'b1; settle();
      check("t6_id1_reaccepted", 32'(iv1), 32'd1);
      commit1();
      cyc(); settle();

      // 4: VFU filter and masked-request acceptance
      pulse_reset();
      send(6, VFU_LoadUnit, 1'b1, '0, 1'b0);
      check("t4_ready_nonmatch", 32'(ready1), 32'd1);
      check("t4_ready_nonmatch_nomask", 32'(ready2), 32'd1);
      cyc(); settle();
      check("t4_nonmatch_empty", 32'(iv1), 32'd0);
      send(6, VFU_LoadUnit, 1'b0, '0, 1'b1);
      cyc(); issue_ready = 1'b1; settle();
      check("t4_masked_accepted", 32'(iv1), 32'd1);
      check("t4_nomask_still_empty", 32'(iv2), 32'd0);
      commit1();
      repeat (3) begin cyc(); settle(); end

      check("end_issue_queue_empty", 32'(exp_issue.size()), 32'd0);
      check("end_done_queue_empty", 32'(exp_done.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
